// File: rtl/mc14599.sv
// 8-bit addressable output latch with registered single-bit readback.
// Define MC14599_READBACK_EN to build the readback register; otherwise dout is tied low.
module mc14599 #(
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d,
    input  logic [2:0] abc,
    input  logic       ce,
    input  logic       rw,
    input  logic       wd,
    input  logic       clr,
    output logic [7:0] q,
    output logic       dout
);

    logic       wr;
    logic [7:0] q_next;

    // rw = 1 blocks writes whether or not the readback path is built
    assign wr = ce & ~rw & ~wd;

    always_comb begin
        q_next = q;
        if (clr) begin
            q_next = 8'h00;
            if (wr) begin
                q_next[abc] = d;
            end
        end else if (wr) begin
            q_next[abc] = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= INIT;
        end else begin
            q <= q_next;
        end
    end

`ifdef MC14599_READBACK_EN
    logic rd;

    assign rd = ce & rw;

    // Captures q[abc] from before this edge, so a coincident clr does not hide the old bit
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 1'b0;
        end else if (rd) begin
            dout <= q[abc];
        end
    end
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_mc14599.sv
// Directed bench for mc14599; dout expectations follow MC14599_READBACK_EN.
module tb_mc14599;

    logic       clk;
    logic       rst;
    logic       d;
    logic [2:0] abc;
    logic       ce;
    logic       rw;
    logic       wd;
    logic       clr;
    logic [7:0] q;
    logic       dout;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

`ifdef MC14599_READBACK_EN
    localparam logic RB = 1'b1;
`else
    localparam logic RB = 1'b0;
`endif

    mc14599 #(.INIT(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .abc (abc),
        .ce  (ce),
        .rw  (rw),
        .wd  (wd),
        .clr (clr),
        .q   (q),
        .dout(dout)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // apply one set of inputs across a rising edge, then settle past it
    task automatic drive(input logic r, input logic c, input logic w, input logic dis,
                         input logic cl, input logic [2:0] a, input logic dv);
        rst = r; ce = c; rw = w; wd = dis; clr = cl; abc = a; d = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0; rw = 1'b0; wd = 1'b0; clr = 1'b0; abc = 3'd0; d = 1'b0;

        // reset
        drive(1, 0, 0, 0, 0, 3'd0, 0);
        check("reset_q", q, 8'hA5);
        check("reset_dout", {7'd0, dout}, 8'h00);

        // clear without write
        drive(0, 0, 0, 0, 1, 3'd0, 0);
        check("clr_only", q, 8'h00);

        // walking write
        exp_q.push_back(8'h01); exp_q.push_back(8'h03);
        exp_q.push_back(8'h07); exp_q.push_back(8'h0F);
        exp_q.push_back(8'h1F); exp_q.push_back(8'h3F);
        exp_q.push_back(8'h7F); exp_q.push_back(8'hFF);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 0, 0, 3'(i), 1);
            check($sformatf("walk%0d", i), q, exp_q.pop_front());
        end

        // write disable
        drive(0, 1, 0, 1, 0, 3'd3, 0);
        check("wd_hold", q, 8'hFF);

        // demultiplex, then clear with ce low
        drive(0, 1, 0, 0, 1, 3'd5, 1);
        check("demux", q, 8'h20);
        drive(0, 0, 0, 0, 1, 3'd5, 1);
        check("clr_ce_low", q, 8'h00);

        // build 8'h5A
        drive(0, 1, 0, 0, 0, 3'd1, 1);
        drive(0, 1, 0, 0, 0, 3'd3, 1);
        drive(0, 1, 0, 0, 0, 3'd4, 1);
        drive(0, 1, 0, 0, 0, 3'd6, 1);
        check("build_5a", q, 8'h5A);

        // reads, with d = 0 so any leaked write would show
        drive(0, 1, 1, 0, 0, 3'd1, 0);
        check("read1_q", q, 8'h5A);
        check("read1_dout", {7'd0, dout}, {7'd0, RB});
        drive(0, 1, 1, 0, 0, 3'd0, 1);
        check("read0_q", q, 8'h5A);
        check("read0_dout", {7'd0, dout}, 8'h00);
        drive(0, 0, 1, 0, 0, 3'd1, 0);
        check("ce_low_dout", {7'd0, dout}, 8'h00);

        // write then read same address
        drive(0, 1, 0, 0, 0, 3'd0, 1);
        check("wr_bit0", q, 8'h5B);
        drive(0, 1, 1, 0, 0, 3'd0, 0);
        check("rd_after_wr", {7'd0, dout}, {7'd0, RB});
        drive(0, 1, 1, 0, 0, 3'd2, 0);
        check("read2_dout", {7'd0, dout}, 8'h00);

        // read / clear collision
        drive(0, 1, 0, 0, 1, 3'd7, 1);
        check("demux_80", q, 8'h80);
        drive(0, 1, 1, 0, 1, 3'd7, 0);
        check("collide_q", q, 8'h00);
        check("collide_dout", {7'd0, dout}, {7'd0, RB});

        // reset discards a coincident write
        drive(1, 1, 0, 0, 0, 3'd0, 0);
        check("rst_mid_q", q, 8'hA5);
        check("rst_mid_dout", {7'd0, dout}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
